uart_tx_sched: RTL and testbench
================================

// Module: uart_tx_sched
// PURPOSE
//  Shares the SoC's single UART transmit line between two byte requesters: 0 = CPU MMIO, 1 = debug/trace.
//  Arbitrates round-robin with line-granular locking, so text lines never interleave.
//  Serialises each byte as 8N1 (or 8N2) on uart_tx.
//  Sits between the SoC bus-side UART register and the uart_tx pin.
// PARAMETERS
//  CLKS_PER_BIT  1    clk cycles per UART bit (1 = the one-bit-per-clock sim decoder); must be >=1
//  STOP_BITS     1    stop bits per frame; legal values 1..2
//  LOCK_TIMEOUT  256  idle cycles after which a held line lock is dropped; must be >=1
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  asynchronous active-low reset
//  req0_valid  in   1  requester 0 has a byte
//  req0_data   in   8  requester 0 byte
//  req0_ready  out  1  requester 0 byte accepted this cycle (when valid)
//  req1_valid  in   1  requester 1 has a byte
//  req1_data   in   8  requester 1 byte
//  req1_ready  out  1  requester 1 byte accepted this cycle (when valid)
//  uart_tx     out  1  serial output; idles high
//  busy        out  1  serialiser not IDLE, or lock held
//  owner       out  1  requester currently holding, or last holding, the lock
// BEHAVIOUR
//  Reset: uart_tx=1, req*_ready=0, busy=0, owner=0, lock=0, rr pointer favours req0, FSM=IDLE.
//   Async reset mid-frame drops uart_tx to 1 immediately, abandons the byte and clears the lock.
//  Handshake: valid/ready. A requester holds valid and data stable until ready.
//   Transfer happens on valid&&ready. ready=(fsm==IDLE)&&(sel==i)&&valid_i.
//  Select, unlocked: if exactly one is valid, select it.
//   If both are valid, select the one not granted last; then the rr pointer flips.
//  Select, locked: only owner is eligible; the other's valid is ignored.
//  Lock: accepting a byte !=8'h0A sets lock and owner=i.
//   Accepting 8'h0A clears lock after that byte.
//  Timeout: counter resets on every accept.
//   Counter increments while lock&&fsm==IDLE&&!owner_valid.
//   At count==LOCK_TIMEOUT, lock clears; the other requester can be granted the next cycle.
//  Serialiser FSM: IDLE -> START -> DATA(8 bits, LSB first) -> STOP -> IDLE.
//   Each bit lasts CLKS_PER_BIT cycles; STOP lasts STOP_BITS*CLKS_PER_BIT cycles.
//   uart_tx is registered: accept in cycle N gives start bit (0) from N+1.
//   Frame = (10 or 11)*CLKS_PER_BIT cycles, plus a 1-cycle IDLE gap between back-to-back bytes.
//  Widths: baud counter max(1,$clog2(CLKS_PER_BIT)); bit index 3b; timeout counter $clog2(LOCK_TIMEOUT+1).
//   No counter wraps: each reloads on state change.
//  Simultaneous: accept and timeout expiry in the same cycle -> accept wins and the counter resets.
//   Lock clears on 0x0A while the other requester is waiting -> the other is granted on the next IDLE.
//  Elaboration-time assertions check the parameter ranges.
// STRUCTURE
//  uart_pkg: tx_state_e {IDLE,START,DATA,STOP}, localparam UART_NEWLINE=8'h0A, typedef req_id_t (1b).
//  Sub-module uart_tx_serializer: FSM, baud counter and shift register, with an in_valid/in_ready/in_data port.
//  Top level holds the arbiter, rr pointer, lock and timeout counter.
// TESTING
//  1 CLKS_PER_BIT=1; req0 0x41 accepted cycle N -> uart_tx=0 at N+1.
//    Bits 1,0,0,0,0,0,1,0 at N+2..N+9; 1 at N+10; ready again at N+11.
//  2 After reset, req0 sends "AB\n" and req1 sends "xy\n", both valid together.
//    -> bench UART prints "AB" then "xy"; req1_ready stays 0 until req0's 0x0A completes.
//  3 Both stream 0x0A bytes continuously -> grants alternate 0,1,0,1; owner toggles every frame.
//  4 LOCK_TIMEOUT=16; req0 sends 'A' then drops valid; req1 valid.
//    -> req1_ready=1 exactly 17 cycles after the serialiser returns to IDLE.
//  5 rst_n low during DATA bit 3 -> uart_tx=1 and ready=0 at once.
//    After release with only req1 valid, req1 0x55 sends a clean frame; owner=1.
//  6 CLKS_PER_BIT=4, STOP_BITS=2; single byte 0xA5 -> 44-cycle frame, each bit held 4 cycles.
//    busy is 1 for the whole frame and while the lock is held.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_pkg;

  // Serialiser frame phases.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

  // Byte that ends a text line and releases the line lock.
  localparam logic [7:0] UART_NEWLINE = 8'h0A;

  // Requester index: 0 = CPU MMIO, 1 = debug/trace.
  typedef logic req_id_t;

  // Baud counter width, never narrower than one bit.
  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1/8N2 byte serialiser: registered line output, LSB first.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       tx
);

  localparam int              CW        = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  tx_state_e       state;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;   // data bit in DATA, stop bit in STOP
  logic [7:0]      shreg;

  assign in_ready = (state == IDLE);

  // Frame sequencer: each bit lasts CLKS_PER_BIT cycles; tx is updated one
  // cycle ahead so it is a clean register output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (in_valid) begin
            state <= START;
            shreg <= in_data;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              state   <= STOP;
              tx      <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx      <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        STOP: begin
          tx <= 1'b1;
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              bit_idx <= '0;
              state   <= IDLE;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Two-requester UART transmit scheduler: round-robin arbitration with
// line-granular locking and an idle timeout, feeding one serialiser.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STOP_BITS    = 1,
  parameter int LOCK_TIMEOUT = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  output logic       req1_ready,
  output logic       uart_tx,
  output logic       busy,
  output logic       owner
);

  if (CLKS_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_tx_sched: CLKS_PER_BIT must be >= 1");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_sched: STOP_BITS must be 1 or 2");
  end
  if (LOCK_TIMEOUT < 1) begin : g_bad_to
    $error("uart_tx_sched: LOCK_TIMEOUT must be >= 1");
  end

  localparam int            TW      = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(LOCK_TIMEOUT);

  logic          lock;
  req_id_t       owner_q;
  req_id_t       rr_ptr;     // requester favoured when both compete
  logic [TW-1:0] to_cnt;

  logic          ser_ready;
  logic          elig0, elig1;
  req_id_t       sel;
  logic          sel_valid;
  logic [7:0]    sel_data;
  logic          accept;
  logic          owner_valid;

  // Eligibility and selection: a held lock shuts out the non-owner.
  always_comb begin
    elig0 = req0_valid && (!lock || owner_q == 1'b0);
    elig1 = req1_valid && (!lock || owner_q == 1'b1);
    if (elig0 && elig1) sel = rr_ptr;
    else if (elig1)     sel = 1'b1;
    else                sel = 1'b0;
    sel_valid   = sel ? elig1 : elig0;
    sel_data    = sel ? req1_data : req0_data;
    owner_valid = owner_q ? req1_valid : req0_valid;
  end

  // rst_n gating keeps ready low while reset is asserted, even though the
  // serialiser already reports IDLE.
  assign accept     = rst_n && ser_ready && sel_valid;
  assign req0_ready = accept && (sel == 1'b0);
  assign req1_ready = accept && (sel == 1'b1);

  // Lock, owner, round-robin pointer and idle-timeout bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock    <= 1'b0;
      owner_q <= 1'b0;
      rr_ptr  <= 1'b0;
      to_cnt  <= '0;
    end else if (accept) begin
      lock    <= (sel_data != UART_NEWLINE);
      owner_q <= sel;
      rr_ptr  <= ~sel;
      to_cnt  <= '0;
    end else if (lock && ser_ready && !owner_valid) begin
      if (to_cnt == TO_LAST) begin
        lock   <= 1'b0;
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + TW'(1);
      end
    end else begin
      to_cnt <= '0;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .STOP_BITS    (STOP_BITS)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (accept),
    .in_data  (sel_data),
    .in_ready (ser_ready),
    .tx       (uart_tx)
  );

  assign busy  = !ser_ready || lock;
  assign owner = owner_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed timing checks plus randomized byte
// streams compared against a frame-level arbitration model.
module tb_uart_tx_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_v0, a_v1, a_r0, a_r1, a_tx, a_busy, a_owner;
  logic [7:0] a_d0, a_d1;
  logic       b_v0, b_v1, b_r0, b_r1, b_tx, b_busy, b_owner;
  logic [7:0] b_d0, b_d1;

  uart_tx_sched #(.CLKS_PER_BIT(1), .STOP_BITS(1), .LOCK_TIMEOUT(16)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
    .uart_tx(a_tx), .busy(a_busy), .owner(a_owner));

  uart_tx_sched #(.CLKS_PER_BIT(4), .STOP_BITS(2), .LOCK_TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .uart_tx(b_tx), .busy(b_busy), .owner(b_owner));

  int total = 0;
  int bad   = 0;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0b exp=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // One-sample-per-bit decoder on dut_a's line (CLKS_PER_BIT=1).
  logic [7:0] dec_q[$];
  int         dstate = 0;
  int         dbit   = 0;
  logic [7:0] dsh;
  always @(negedge clk) begin
    if (!rst_n) begin
      dstate = 0;
    end else begin
      case (dstate)
        0: if (a_tx === 1'b0) begin dstate = 1; dbit = 0; end
        1: begin
          dsh[dbit] = a_tx;
          dbit++;
          if (dbit == 8) dstate = 2;
        end
        default: begin
          chk1("stop_bit", a_tx, 1'b1);
          dec_q.push_back(dsh);
          dstate = 0;
        end
      endcase
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    a_v0 = 0; a_v1 = 0; a_d0 = 0; a_d1 = 0;
    b_v0 = 0; b_v1 = 0; b_d0 = 0; b_d1 = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    dec_q.delete();
  endtask

  // Byte streams for run_stream; each requester keeps valid up while it has bytes.
  logic [7:0] tq0[$], tq1[$];

  task automatic run_stream(input string name);
    logic [7:0] m0[$], m1[$], eb[$];
    bit         es[$];
    bit         last = 1'b1, lk = 1'b0, ow = 1'b0, pick, acc0, acc1;
    logic [7:0] b;
    int         gi = 0, cyc = 0;
    // Frame-level model: owner keeps the line until newline or until it runs
    // dry (timeout); otherwise the requester not granted last wins a tie.
    m0 = tq0; m1 = tq1;
    while (m0.size() > 0 || m1.size() > 0) begin
      if (lk && ((ow == 1'b0 && m0.size() == 0) || (ow == 1'b1 && m1.size() == 0))) lk = 1'b0;
      if (lk)                                pick = ow;
      else if (m0.size() > 0 && m1.size() > 0) pick = !last;
      else                                   pick = (m0.size() == 0);
      b = pick ? m1.pop_front() : m0.pop_front();
      es.push_back(pick); eb.push_back(b);
      last = pick; lk = (b != 8'h0A); ow = pick;
    end

    do_reset();
    a_v0 = (tq0.size() > 0); a_d0 = a_v0 ? tq0[0] : 8'h00;
    a_v1 = (tq1.size() > 0); a_d1 = a_v1 ? tq1[0] : 8'h00;
    while ((tq0.size() > 0 || tq1.size() > 0 || dec_q.size() < eb.size()) && cyc < 4000) begin
      @(negedge clk);
      acc0 = a_v0 && a_r0;
      acc1 = a_v1 && a_r1;
      @(posedge clk); #1;
      cyc++;
      if (acc0 || acc1) begin
        chk1({name, " single_grant"}, acc0 && acc1, 1'b0);
        if (gi < es.size()) begin
          chk1($sformatf("%s grant%0d_src", name, gi), acc1, es[gi]);
          chk1($sformatf("%s grant%0d_owner", name, gi), a_owner, es[gi]);
        end
        gi++;
        if (acc0) void'(tq0.pop_front());
        if (acc1) void'(tq1.pop_front());
        a_v0 = (tq0.size() > 0); a_d0 = a_v0 ? tq0[0] : 8'h00;
        a_v1 = (tq1.size() > 0); a_d1 = a_v1 ? tq1[0] : 8'h00;
      end
    end
    chk1({name, " in_budget"}, cyc < 4000, 1'b1);
    chki({name, " grant_count"}, gi, es.size());
    chki({name, " byte_count"}, dec_q.size(), eb.size());
    for (int i = 0; i < eb.size() && i < dec_q.size(); i++)
      chk8($sformatf("%s byte%0d", name, i), dec_q[i], eb[i]);
  endtask

  initial begin
    logic [9:0] fr;
    logic [7:0] v;
    logic       e;
    int         n;

    // Reset state
    do_reset();
    #1;
    chk1("rst a_tx", a_tx, 1'b1);
    chk1("rst a_busy", a_busy, 1'b0);
    chk1("rst a_owner", a_owner, 1'b0);
    chk1("rst a_r0", a_r0, 1'b0);
    chk1("rst a_r1", a_r1, 1'b0);
    chk1("rst b_tx", b_tx, 1'b1);
    chk1("rst b_busy", b_busy, 1'b0);

    // Single 0x41 frame, cycle-exact, then a 0x0A held behind it
    a_v0 = 1; a_d0 = 8'h41;
    @(negedge clk);
    chk1("t1 ready_N", a_r0, 1'b1);
    @(posedge clk); #1;
    a_d0 = 8'h0A;
    fr = {1'b1, 8'h41, 1'b0};
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk1($sformatf("t1 tx N+%0d", k), a_tx, fr[k-1]);
      chk1($sformatf("t1 ready N+%0d", k), a_r0, 1'b0);
    end
    @(negedge clk);
    chk1("t1 ready N+11", a_r0, 1'b1);
    @(posedge clk); #1;
    a_v0 = 0;
    repeat (12) @(negedge clk);
    chki("t1 nbytes", dec_q.size(), 2);
    if (dec_q.size() == 2) begin
      chk8("t1 byte0", dec_q[0], 8'h41);
      chk8("t1 byte1", dec_q[1], 8'h0A);
    end
    chk1("t1 busy_after_nl", a_busy, 1'b0);

    // Lines from both requesters never interleave
    tq0 = '{8'h41, 8'h42, 8'h0A};
    tq1 = '{8'h78, 8'h79, 8'h0A};
    run_stream("t2");

    // Continuous newlines alternate grants
    tq0 = '{8'h0A, 8'h0A, 8'h0A, 8'h0A};
    tq1 = '{8'h0A, 8'h0A, 8'h0A, 8'h0A};
    run_stream("t3");

    // Lock timeout: req1 granted 17 cycles after the serialiser goes idle
    do_reset();
    a_v0 = 1; a_d0 = 8'h41;
    @(negedge clk);
    chk1("t4 r0", a_r0, 1'b1);
    @(posedge clk); #1;
    a_v0 = 0; a_v1 = 1; a_d1 = 8'h0A;
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      chk1($sformatf("t4 r1 N+%0d", k), a_r1, k == 28);
    end
    @(posedge clk); #1;
    a_v1 = 0;
    chk1("t4 owner", a_owner, 1'b1);

    // Async reset during DATA bit 3
    do_reset();
    a_v0 = 1; a_d0 = 8'h41;
    @(negedge clk);
    chk1("t5 r0", a_r0, 1'b1);
    @(posedge clk); #1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("t5 tx_in_reset", a_tx, 1'b1);
    chk1("t5 r0_in_reset", a_r0, 1'b0);
    chk1("t5 busy_in_reset", a_busy, 1'b0);
    a_v0 = 0; a_v1 = 1; a_d1 = 8'h55;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    dec_q.delete();
    @(negedge clk);
    chk1("t5 r1", a_r1, 1'b1);
    @(posedge clk); #1;
    a_v1 = 0;
    chk1("t5 owner", a_owner, 1'b1);
    repeat (12) @(negedge clk);
    chki("t5 nbytes", dec_q.size(), 1);
    if (dec_q.size() == 1) chk8("t5 byte", dec_q[0], 8'h55);

    // Randomized streams
    for (int r = 0; r < 4; r++) begin
      tq0.delete(); tq1.delete();
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++)
        tq0.push_back(($urandom_range(0, 2) == 0) ? 8'h0A : 8'($urandom_range(32, 126)));
      n = $urandom_range(2, 6);
      for (int i = 0; i < n; i++)
        tq1.push_back(($urandom_range(0, 2) == 0) ? 8'h0A : 8'($urandom_range(32, 126)));
      run_stream($sformatf("rnd%0d", r));
    end

    // CLKS_PER_BIT=4, STOP_BITS=2: 44-cycle frame for 0xA5
    do_reset();
    b_v0 = 1; b_d0 = 8'hA5;
    @(negedge clk);
    chk1("t6 r0", b_r0, 1'b1);
    @(posedge clk); #1;
    b_v0 = 0;
    v = 8'hA5;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k <= 4)       e = 1'b0;
      else if (k <= 36) e = v[(k-5)/4];
      else              e = 1'b1;
      chk1($sformatf("t6 tx N+%0d", k), b_tx, e);
      chk1($sformatf("t6 busy N+%0d", k), b_busy, 1'b1);
    end
    repeat (30) @(negedge clk);
    chk1("t6 busy_after_timeout", b_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
